// File: rtl/mem_stage.sv
// MIPS memory stage: latches execute results, runs byte/half/word loads and stores over req/ack.
// Latency: 1 cycle for non-memory ops, 2+ cycles for memory ops; execute is stalled while ACCESS is busy.
module mem_stage #(
  parameter int DWIDTH   = 32,
  parameter int PC_WIDTH = 32,
  parameter int AWIDTH   = 32
) (
  input  logic                m_i_clk,
  input  logic                m_i_rst_n,
  input  logic                m_i_valid,
  input  logic [DWIDTH-1:0]   m_i_alu_value,
  input  logic [DWIDTH-1:0]   m_i_store_data,
  input  logic [4:0]          m_i_rd_addr,
  input  logic                m_i_reg_write,
  input  logic                m_i_mem_read,
  input  logic                m_i_mem_write,
  input  logic [1:0]          m_i_size,
  input  logic                m_i_unsigned,
  input  logic                m_i_change_pc,
  input  logic [PC_WIDTH-1:0] m_i_alu_pc,
  output logic                m_o_stall,
  output logic                m_o_dmem_req,
  output logic                m_o_dmem_we,
  output logic [AWIDTH-1:0]   m_o_dmem_addr,
  output logic [DWIDTH-1:0]   m_o_dmem_wdata,
  output logic [3:0]          m_o_dmem_wstrb,
  input  logic                m_i_dmem_ack,
  input  logic [DWIDTH-1:0]   m_i_dmem_rdata,
  output logic                m_o_valid,
  output logic [DWIDTH-1:0]   m_o_wb_data,
  output logic [4:0]          m_o_rd_addr,
  output logic                m_o_reg_write,
  output logic                m_o_change_pc,
  output logic [PC_WIDTH-1:0] m_o_pc,
  output logic                m_o_misalign
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic [1:0]  lat_size;
  logic [1:0]  lat_lane;
  logic        lat_unsigned;
  logic        lat_store;

  logic              accept;
  logic              is_mem;
  logic              misal;
  logic [3:0]        st_wstrb;
  logic [DWIDTH-1:0] st_wdata;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [DWIDTH-1:0] ld_data;

  assign m_o_stall = (state == ACCESS);
  assign accept    = m_i_valid && (state == IDLE);
  assign is_mem    = m_i_mem_read || m_i_mem_write;
  // size 11 falls into the word check through size[1]
  assign misal     = is_mem && (((m_i_size == 2'b01) && m_i_alu_value[0]) ||
                                (m_i_size[1] && (m_i_alu_value[1:0] != 2'b00)));

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = m_i_store_data;
    case (m_i_size)
      2'b00: begin
        st_wstrb = 4'b0001 << m_i_alu_value[1:0];
        st_wdata = {4{m_i_store_data[7:0]}};
      end
      2'b01: begin
        st_wstrb = m_i_alu_value[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{m_i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = m_i_dmem_rdata[7:0];
    case (lat_lane)
      2'b01:   ld_byte = m_i_dmem_rdata[15:8];
      2'b10:   ld_byte = m_i_dmem_rdata[23:16];
      2'b11:   ld_byte = m_i_dmem_rdata[31:24];
      default: ;
    endcase
    ld_half = lat_lane[1] ? m_i_dmem_rdata[31:16] : m_i_dmem_rdata[15:0];
    ld_data = m_i_dmem_rdata;
    case (lat_size)
      2'b00:   ld_data = lat_unsigned ? {{(DWIDTH-8){1'b0}}, ld_byte}
                                      : {{(DWIDTH-8){ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = lat_unsigned ? {{(DWIDTH-16){1'b0}}, ld_half}
                                      : {{(DWIDTH-16){ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  always_ff @(posedge m_i_clk or negedge m_i_rst_n) begin
    if (!m_i_rst_n) begin
      state          <= IDLE;
      lat_size       <= 2'b00;
      lat_lane       <= 2'b00;
      lat_unsigned   <= 1'b0;
      lat_store      <= 1'b0;
      m_o_dmem_req   <= 1'b0;
      m_o_dmem_we    <= 1'b0;
      m_o_dmem_addr  <= '0;
      m_o_dmem_wdata <= '0;
      m_o_dmem_wstrb <= 4'b0000;
      m_o_valid      <= 1'b0;
      m_o_wb_data    <= '0;
      m_o_rd_addr    <= 5'd0;
      m_o_reg_write  <= 1'b0;
      m_o_change_pc  <= 1'b0;
      m_o_pc         <= '0;
      m_o_misalign   <= 1'b0;
    end else begin
      m_o_valid     <= 1'b0;
      m_o_change_pc <= 1'b0;
      m_o_pc        <= '0;
      m_o_misalign  <= 1'b0;

      if (accept) begin
        m_o_change_pc <= m_i_change_pc;
        m_o_pc        <= m_i_change_pc ? m_i_alu_pc : '0;
        m_o_wb_data   <= m_i_alu_value;
        m_o_rd_addr   <= m_i_rd_addr;
        m_o_reg_write <= m_i_reg_write && !m_i_mem_write && !misal;
        if (is_mem && !misal) begin
          state          <= ACCESS;
          lat_size       <= m_i_size;
          lat_lane       <= m_i_alu_value[1:0];
          lat_unsigned   <= m_i_unsigned;
          lat_store      <= m_i_mem_write;
          m_o_dmem_req   <= 1'b1;
          m_o_dmem_we    <= m_i_mem_write;
          m_o_dmem_addr  <= {m_i_alu_value[AWIDTH-1:2], 2'b00};
          m_o_dmem_wdata <= st_wdata;
          m_o_dmem_wstrb <= m_i_mem_write ? st_wstrb : 4'b0000;
        end else begin
          m_o_valid    <= 1'b1;
          m_o_misalign <= misal;
        end
      end else if ((state == ACCESS) && m_i_dmem_ack) begin
        state          <= IDLE;
        m_o_valid      <= 1'b1;
        m_o_dmem_req   <= 1'b0;
        m_o_dmem_we    <= 1'b0;
        m_o_dmem_wstrb <= 4'b0000;
        if (!lat_store) m_o_wb_data <= ld_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: scoreboard of expected write-backs plus direct checks of the memory port.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic [31:0] i_alu_value;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd_addr;
  logic        i_reg_write;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [1:0]  i_size;
  logic        i_unsigned;
  logic        i_change_pc;
  logic [31:0] i_alu_pc;
  logic        o_stall;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write;
  logic        o_change_pc;
  logic [31:0] o_pc;
  logic        o_misalign;

  always #5 clk = ~clk;

  mem_stage dut (
    .m_i_clk        (clk),
    .m_i_rst_n      (rst_n),
    .m_i_valid      (i_valid),
    .m_i_alu_value  (i_alu_value),
    .m_i_store_data (i_store_data),
    .m_i_rd_addr    (i_rd_addr),
    .m_i_reg_write  (i_reg_write),
    .m_i_mem_read   (i_mem_read),
    .m_i_mem_write  (i_mem_write),
    .m_i_size       (i_size),
    .m_i_unsigned   (i_unsigned),
    .m_i_change_pc  (i_change_pc),
    .m_i_alu_pc     (i_alu_pc),
    .m_o_stall      (o_stall),
    .m_o_dmem_req   (o_dmem_req),
    .m_o_dmem_we    (o_dmem_we),
    .m_o_dmem_addr  (o_dmem_addr),
    .m_o_dmem_wdata (o_dmem_wdata),
    .m_o_dmem_wstrb (o_dmem_wstrb),
    .m_i_dmem_ack   (i_dmem_ack),
    .m_i_dmem_rdata (i_dmem_rdata),
    .m_o_valid      (o_valid),
    .m_o_wb_data    (o_wb_data),
    .m_o_rd_addr    (o_rd_addr),
    .m_o_reg_write  (o_reg_write),
    .m_o_change_pc  (o_change_pc),
    .m_o_pc         (o_pc),
    .m_o_misalign   (o_misalign)
  );

  typedef struct {
    logic [31:0] wb;
    logic [4:0]  rd;
    logic        rw;
    logic        mis;
    logic        cpc;
    logic [31:0] pc;
    logic        chk_wb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] wb, input logic [4:0] rd, input logic rw,
                      input logic mis, input logic cpc, input logic [31:0] pc, input logic chk_wb);
    exp_t e;
    e.wb = wb; e.rd = rd; e.rw = rw; e.mis = mis; e.cpc = cpc; e.pc = pc; e.chk_wb = chk_wb;
    sb.push_back(e);
  endtask

  // Caller is just after a rising edge; the op is accepted at the next one.
  task automatic send(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                      input logic rw, input logic mr, input logic mw, input logic [1:0] sz,
                      input logic us, input logic cpc, input logic [31:0] apc);
    i_valid = 1'b1; i_alu_value = alu; i_store_data = sd; i_rd_addr = rd;
    i_reg_write = rw; i_mem_read = mr; i_mem_write = mw; i_size = sz;
    i_unsigned = us; i_change_pc = cpc; i_alu_pc = apc;
    @(posedge clk); #1;
    i_valid = 1'b0; i_alu_value = '0; i_store_data = '0; i_rd_addr = '0;
    i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = 2'b00;
    i_unsigned = 1'b0; i_change_pc = 1'b0; i_alu_pc = '0;
  endtask

  // Acks on the delay-th access cycle; checks the request is held every cycle it is up.
  task automatic mem_access(input logic [31:0] addr, input logic we, input logic [3:0] wstrb,
                            input logic [31:0] wdata, input logic chk_wd,
                            input logic [31:0] rdata, input int delay);
    for (int i = 0; i < delay; i++) begin
      @(negedge clk);
      chk("req", o_dmem_req, 1'b1);
      chk("stall", o_stall, 1'b1);
      chk("addr", o_dmem_addr, addr);
      chk("we", o_dmem_we, we);
      chk("wstrb", o_dmem_wstrb, wstrb);
      if (chk_wd) chk("wdata", o_dmem_wdata, wdata);
      if (i == delay - 1) begin
        i_dmem_ack = 1'b1;
        i_dmem_rdata = rdata;
      end
    end
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = '0;
    @(negedge clk);
    chk("req_done", o_dmem_req, 1'b0);
    chk("stall_done", o_stall, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && o_valid) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected", o_valid, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.chk_wb) chk("wb_data", o_wb_data, mon_e.wb);
        chk("wb_rd", o_rd_addr, mon_e.rd);
        chk("wb_reg_write", o_reg_write, mon_e.rw);
        chk("wb_misalign", o_misalign, mon_e.mis);
        chk("wb_change_pc", o_change_pc, mon_e.cpc);
        chk("wb_pc", o_pc, mon_e.pc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    i_valid = 1'b0; i_alu_value = '0; i_store_data = '0; i_rd_addr = '0;
    i_reg_write = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = 2'b00;
    i_unsigned = 1'b0; i_change_pc = 1'b0; i_alu_pc = '0;
    i_dmem_ack = 1'b0; i_dmem_rdata = '0;

    @(negedge clk);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_stall", o_stall, 1'b0);
    chk("rst_req", o_dmem_req, 1'b0);
    chk("rst_wb", o_wb_data, 32'h0);
    chk("rst_cpc", o_change_pc, 1'b0);
    chk("rst_misalign", o_misalign, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // add
    push(32'h1234, 5'd5, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    send(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("valid_drop", o_valid, 1'b0);

    // lb / lbu at 0x103, ack on third access cycle
    @(posedge clk); #1;
    push(32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    send(32'h103, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 32'h0);
    mem_access(32'h100, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h80FF_FF7F, 3);
    @(posedge clk); #1;
    push(32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    send(32'h103, 32'h0, 5'd8, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 32'h0);
    mem_access(32'h100, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h80FF_FF7F, 1);

    // lh upper half, lw with size 11
    @(posedge clk); #1;
    push(32'hFFFF_8001, 5'd10, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    send(32'h102, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 32'h0);
    mem_access(32'h100, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h8001_1234, 2);
    @(posedge clk); #1;
    push(32'hDEAD_BEEF, 5'd11, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    send(32'h104, 32'h0, 5'd11, 1'b1, 1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 32'h0);
    mem_access(32'h104, 1'b0, 4'b0000, 32'h0, 1'b0, 32'hDEAD_BEEF, 1);

    // sh at 0x202; reg_write must be forced low
    @(posedge clk); #1;
    push(32'h0, 5'd6, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send(32'h202, 32'h0000_ABCD, 5'd6, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 32'h0);
    mem_access(32'h200, 1'b1, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h0, 1);

    // sb at 0x101 with both read and write set: behaves as a store
    @(posedge clk); #1;
    push(32'h0, 5'd12, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    send(32'h101, 32'h1234_565A, 5'd12, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 32'h0);
    mem_access(32'h100, 1'b1, 4'b0010, 32'h5A5A_5A5A, 1'b1, 32'hFFFF_FFFF, 2);

    // misaligned lw, then an add accepted the very next cycle
    @(posedge clk); #1;
    push(32'h0, 5'd3, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    push(32'h55, 5'd4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    send(32'h101, 32'h0, 5'd3, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    send(32'h55, 32'h0, 5'd4, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("misal_noreq", o_dmem_req, 1'b0);
    chk("misal_nostall", o_stall, 1'b0);
    @(negedge clk);
    chk("misal_drop", o_misalign, 1'b0);

    // taken branch
    @(posedge clk); #1;
    push(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
    send(32'h1, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 32'h40);
    @(negedge clk);
    chk("cpc_pulse", o_change_pc, 1'b1);
    chk("pc_pulse", o_pc, 32'h40);
    @(negedge clk);
    chk("cpc_drop", o_change_pc, 1'b0);
    chk("pc_drop", o_pc, 32'h0);

    // reset in the middle of an access, then a late ack
    @(posedge clk); #1;
    send(32'h300, 32'h0, 5'd9, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("rst_pre_req", o_dmem_req, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_req", o_dmem_req, 1'b0);
    chk("rst_mid_stall", o_stall, 1'b0);
    chk("rst_mid_valid", o_valid, 1'b0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h1111_1111;
    @(posedge clk); #1;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = '0;
    @(negedge clk);
    chk("late_ack_valid", o_valid, 1'b0);
    chk("late_ack_stall", o_stall, 1'b0);
    chk("late_ack_req", o_dmem_req, 1'b0);

    @(posedge clk); #1;
    push(32'h77, 5'd2, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    send(32'h77, 32'h0, 5'd2, 1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
